// File: rtl/status_reg_pkg.sv
// Shared constants for the 6502 processor status register: flag bit positions,
// control opcodes and the branch-condition helper.
package status_reg_pkg;

  localparam int unsigned C_FLAG_SHFT_C = 0;
  localparam int unsigned C_FLAG_SHFT_Z = 1;
  localparam int unsigned C_FLAG_SHFT_I = 2;
  localparam int unsigned C_FLAG_SHFT_D = 3;
  localparam int unsigned C_FLAG_SHFT_B = 4;
  localparam int unsigned C_FLAG_SHFT_X = 5;
  localparam int unsigned C_FLAG_SHFT_V = 6;
  localparam int unsigned C_FLAG_SHFT_N = 7;

  // Bits 5 and 4 have no storage; they always read as 1.
  localparam logic [7:0] C_P_FIXED_ONES = 8'h30;

  typedef enum logic [2:0] {
    C_SR_CTRL_NOP = 3'd0,
    C_SR_CTRL_ALU = 3'd1,
    C_SR_CTRL_SET = 3'd2,
    C_SR_CTRL_CLR = 3'd3,
    C_SR_CTRL_PLP = 3'd4,
    C_SR_CTRL_INT = 3'd5
  } sr_ctrl_e;

  // Branch opcode bits [7:6] pick N/V/C/Z, bit [5] is the polarity to match.
  function automatic logic branch_cond(input logic [7:0] p, input logic [2:0] cond_sel);
    logic flag;
    case (cond_sel[2:1])
      2'd0:    flag = p[C_FLAG_SHFT_N];
      2'd1:    flag = p[C_FLAG_SHFT_V];
      2'd2:    flag = p[C_FLAG_SHFT_C];
      default: flag = p[C_FLAG_SHFT_Z];
    endcase
    return flag ~^ cond_sel[0];
  endfunction

endpackage

// File: rtl/status_reg_sync_fall.sv
// Multi-stage synchronizer for an asynchronous active-low pin, followed by a
// one-cycle pulse on each falling edge of the synchronized value.
module status_reg_sync_fall #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
      last_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      last_reg <= sync_reg[STAGES-1];
    end
  end

  assign fall = last_reg & ~sync_reg[STAGES-1];

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register (P): flag updates, stack push value, branch
// condition, SO-pin overflow set and the one-instruction-delayed IRQ mask.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0]  RESET_P        = 8'h34,
  parameter int unsigned SO_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] FLAG_ALU,
  input  logic [7:0] FLAG_WE,
  input  logic [2:0] CTRL,
  input  logic [2:0] SEL,
  input  logic [7:0] DB_IN,
  input  logic       BRK,
  input  logic       SO_N,
  input  logic       IRQ_N,
  input  logic       SYNC,
  input  logic [2:0] COND_SEL,
  output logic [7:0] P,
  output logic [7:0] PUSH_DATA,
  output logic       COND,
  output logic       IRQ_REQ
);

  logic [7:0] p_reg;
  logic [7:0] p_next;
  logic [7:0] alu_bits;
  logic       irq_req_reg;
  logic       i_prev_reg;
  logic       so_fall;
  sr_ctrl_e   ctrl_op;

  status_reg_sync_fall #(
    .STAGES (SO_SYNC_STAGES)
  ) u_so_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (SO_N),
    .fall  (so_fall)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_alu_mask
      assign alu_bits[gi] = FLAG_WE[gi] ? FLAG_ALU[gi] : p_reg[gi];
    end
  endgenerate

  assign ctrl_op = sr_ctrl_e'(CTRL);

  always_comb begin
    p_next = p_reg;
    case (ctrl_op)
      C_SR_CTRL_ALU: p_next = alu_bits;
      C_SR_CTRL_SET: begin
        if (SEL != 3'(C_FLAG_SHFT_B) && SEL != 3'(C_FLAG_SHFT_X))
          p_next[SEL] = 1'b1;
      end
      C_SR_CTRL_CLR: begin
        if (SEL != 3'(C_FLAG_SHFT_B) && SEL != 3'(C_FLAG_SHFT_X))
          p_next[SEL] = 1'b0;
      end
      C_SR_CTRL_PLP: p_next = DB_IN;
      C_SR_CTRL_INT: p_next[C_FLAG_SHFT_I] = 1'b1;
      default:       p_next = p_reg;
    endcase
    // SO wins over any same-cycle write of V; the rest of that write stands.
    if (so_fall)
      p_next[C_FLAG_SHFT_V] = 1'b1;
    p_next = p_next | C_P_FIXED_ONES;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_reg       <= RESET_P | C_P_FIXED_ONES;
      irq_req_reg <= 1'b0;
      i_prev_reg  <= 1'b1;
    end else begin
      p_reg <= p_next;
      // I sampled here only gates the IRQ at the following SYNC.
      if (SYNC) begin
        irq_req_reg <= ~IRQ_N & ~i_prev_reg;
        i_prev_reg  <= p_reg[C_FLAG_SHFT_I];
      end
    end
  end

  assign P         = p_reg;
  assign IRQ_REQ   = irq_req_reg;
  assign PUSH_DATA = {p_reg[7:6], 1'b1, BRK, p_reg[3:0]};
  assign COND      = branch_cond(p_reg, COND_SEL);

endmodule
